regfile_param: RTL and testbench
================================

# regfile_param

Parametrised register file with two combinational read ports and one clocked write port, word width and depth set at elaboration. Successor to the fixed 32×64 datapath register file: adds a synchronous active-high reset that clears the whole array with a hardware sequencer, a `Ready` status output, a configurable hardwired-zero register, and optional write-to-read bypass. It sits in the single-cycle datapath between decode (`RA`/`RB`/`RW`) and the ALU/writeback mux (`BusA`/`BusB`/`BusW`).

## Interface
- `DATA_W`, 64, width of each register and of every data bus.
- `ADDR_W`, 5, register index width; `DEPTH = 2**ADDR_W` entries.
- `ZERO_REG`, 31, index of the hardwired-zero register. Legal range is 0..DEPTH-1.
- `Clk`  in  1  single clock; all state updates on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `RA`  in  ADDR_W  read address, port A.
- `RB`  in  ADDR_W  read address, port B.
- `RW`  in  ADDR_W  write address.
- `BusW`  in  DATA_W  write data.
- `RegWr`  in  1  write enable.
- `BusA`  out  DATA_W  read data, port A.
- `BusB`  out  DATA_W  read data, port B.
- `Ready`  out  1  high once the clear sequence has completed; registered.

## Operation
- The FSM has two states, INIT and RUN, and a clear counter `clr_idx` that is ADDR_W bits wide.
- **Reset high:** state becomes INIT, `clr_idx` becomes 0, `Ready` becomes 0. The array is not written while `Reset` is high.
- **INIT, with Reset low:** each rising edge writes 0 to `mem[clr_idx]`.
  - When `clr_idx == DEPTH-1`, that final write happens, the state moves to RUN and `Ready` becomes 1.
  - Otherwise `clr_idx` increments.
  - `RegWr` is ignored in INIT.
- **RUN:** a rising edge with `RegWr=1` and `RW != ZERO_REG` writes `BusW` to `mem[RW]`. A write to `ZERO_REG` is silently dropped.
- **Reads:** `BusA = (RA == ZERO_REG) ? 0 : mem[RA]`, and the same for `BusB` with `RB`.
  - Reads are purely combinational.
  - Both ports may address the same register.
  - While `Ready=0`, `BusA` and `BusB` are forced to 0.
- **Reset in the middle of INIT or RUN:** the next edge with `Reset` high returns the block to INIT with `clr_idx=0`. The full clear sequence then restarts, with no partial carry-over.
- **Reset values:** `Ready=0`, `BusA=0`, `BusB=0`.

## Timing
- Read latency is zero cycles, address to data, combinational.
- A write is committed at edge N. Without bypass, the new value appears on the read ports after edge N.
- Clear duration:
  - After `Reset` falls before edge k, edges k .. k+DEPTH-1 perform the clears.
  - `Ready` is 1 after edge k+DEPTH-1, i.e. DEPTH cycles after reset deasserts.
  - With the default parameters that is 32 cycles.
- The first accepted `RegWr` is at the first edge with `Ready=1` already high. A write presented during the same cycle that `Ready` rises is dropped.
- `Reset` has priority over INIT clearing and over `RegWr`.

## Configuration
- Macro: `REGFILE_BYPASS_EN`.
- **Defined:** read-during-write forwarding.
  - Condition: `Ready=1`, `RegWr=1`, `RW != ZERO_REG` and `RA == RW`.
  - Then `BusA = BusW` combinationally, in the same cycle and before the edge. `BusB` behaves the same way with `RB`.
  - `ZERO_REG` still reads 0 on either port.
- **Undefined:** no forwarding. Reads return the array contents, i.e. the old value, until the write edge.

## Test plan
- **Clear sequence:** hold `Reset` for 3 cycles, then release. `Ready` must stay 0 for exactly 32 edges and then go to 1. Reading all 32 entries afterwards gives 0x0. `RegWr=1` with `RW=5` and `BusW=0xDEAD` during INIT leaves `mem[5]` at 0.
- **Basic write/read:** in RUN, write `RW=3`, `BusW=0x0123456789ABCDEF`. After the edge, `RA=3` and `RB=3` both read 0x0123456789ABCDEF.
- **Zero register:** write `RW=31`, `BusW=0xFFFF_FFFF_FFFF_FFFF`. `RA=31` reads 0. Rerun with `ZERO_REG=0`: `RA=0` reads 0 and `RA=31` holds the written value.
- **Bypass:**
  - Setup: `RegWr=1`, `RW=RA=7`, `BusW=0xAA`, old `mem[7]=0x55`.
  - With `REGFILE_BYPASS_EN`, `BusA=0xAA` before the edge.
  - Without it, `BusA=0x55` before the edge and `0xAA` after.
- **Reset mid-operation:** write `mem[4]=0x77`. Assert `Reset` for 1 cycle at clear index 10 of a second INIT. `Ready` must then take another full 32 edges, and `mem[4]` reads 0.
- **Parametrisation:** with `DATA_W=32` and `ADDR_W=3`, `Ready` rises 8 edges after reset deasserts. Writing 0xCAFEBABE to `RW=6` reads back on `RB=6`.

Source files
------------

// File: rtl/regfile_param.sv
// regfile_param: 2-read/1-write register file with a reset-driven clear sequencer and hardwired-zero entry.
// Define REGFILE_BYPASS_EN to forward BusW onto a read port addressing the register being written.
module regfile_param #(
   parameter int DATA_W   = 64,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 31
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [ADDR_W-1:0] RA,
   input  logic [ADDR_W-1:0] RB,
   input  logic [ADDR_W-1:0] RW,
   input  logic [DATA_W-1:0] BusW,
   input  logic              RegWr,
   output logic [DATA_W-1:0] BusA,
   output logic [DATA_W-1:0] BusB,
   output logic              Ready
);
   localparam int DEPTH = 2**ADDR_W;
   localparam logic [0:0] INIT = 1'b0, RUN = 1'b1;
   localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);
   localparam logic [ADDR_W-1:0] LAST = '1;
`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   logic [0:0] state;
   logic [ADDR_W-1:0] clrIdx, memAddr;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] memData;
   logic wrEn, memWe;
   assign wrEn = Ready && RegWr && RW != ZR;
   always_ff @(posedge Clk)
      if (Reset) begin
         state  <= INIT;
         clrIdx <= '0;
         Ready  <= 1'b0;
      end else if (state == INIT) begin
         if (clrIdx == LAST) begin
            state <= RUN;
            Ready <= 1'b1;
         end else clrIdx <= clrIdx + 1'b1;
      end
   // the clear sequencer and the user write port share the single array write port
   always_comb begin
      memWe   = !Reset && (state == INIT || wrEn);
      memAddr = state == INIT ? clrIdx : RW;
      memData = state == INIT ? '0 : BusW;
   end
   always_ff @(posedge Clk)
      if (memWe) mem[memAddr] <= memData;
   always_comb begin
      BusA = (!Ready || RA == ZR) ? '0 : (BYP && wrEn && RA == RW) ? BusW : mem[RA];
      BusB = (!Ready || RB == ZR) ? '0 : (BYP && wrEn && RB == RW) ? BusW : mem[RB];
   end
endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: randomized and directed checks of three regfile_param configurations against a behavioural model.
module tb_regfile_param;
`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic Reset = 1'b1, RegWr = 1'b0;
   logic [4:0] RA = '0, RB = '0, RW = '0;
   logic [63:0] BusW = '0;
   logic [63:0] a0, b0, a1, b1;
   logic [31:0] a2, b2;
   logic r0, r1, r2;
   int errors = 0, checks = 0;

   regfile_param u0 (.Clk(clk), .Reset(Reset), .RA(RA), .RB(RB), .RW(RW), .BusW(BusW), .RegWr(RegWr),
                     .BusA(a0), .BusB(b0), .Ready(r0));
   regfile_param #(.ZERO_REG(0)) u1 (.Clk(clk), .Reset(Reset), .RA(RA), .RB(RB), .RW(RW), .BusW(BusW),
                     .RegWr(RegWr), .BusA(a1), .BusB(b1), .Ready(r1));
   regfile_param #(.DATA_W(32), .ADDR_W(3), .ZERO_REG(7)) u2 (.Clk(clk), .Reset(Reset), .RA(RA[2:0]),
                     .RB(RB[2:0]), .RW(RW[2:0]), .BusW(BusW[31:0]), .RegWr(RegWr), .BusA(a2), .BusB(b2),
                     .Ready(r2));

   // model: per instance, count clear edges since reset; contents become all-zero once the count reaches depth
   logic [63:0] mm [3][32];
   int cnt [3];
   bit rdy [3];
   function automatic int zr(int k); return k == 0 ? 31 : k == 1 ? 0 : 7; endfunction
   function automatic int dp(int k); return k == 2 ? 8 : 32; endfunction
   function automatic logic [63:0] dm(int k); return k == 2 ? 64'hFFFF_FFFF : '1; endfunction

   initial for (int k = 0; k < 3; k++) begin cnt[k] = 0; rdy[k] = 1'b0; end

   always @(posedge clk)
      for (int k = 0; k < 3; k++) begin
         if (Reset) begin
            cnt[k] = 0;
            rdy[k] = 1'b0;
         end else if (!rdy[k]) begin
            cnt[k]++;
            if (cnt[k] == dp(k)) begin
               rdy[k] = 1'b1;
               for (int i = 0; i < 32; i++) mm[k][i] = '0;
            end
         end else if (RegWr && int'(RW) % dp(k) != zr(k))
            mm[k][int'(RW) % dp(k)] = BusW & dm(k);
      end

   function automatic logic [63:0] expRd(int k, logic [4:0] a);
      int x = int'(a) % dp(k);
      int w = int'(RW) % dp(k);
      if (!rdy[k] || x == zr(k)) return '0;
      if (BYP && RegWr && w != zr(k) && x == w) return BusW & dm(k);
      return mm[k][x];
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always begin
      @(negedge clk);
      #2;
      chk("ready0", 64'(r0), 64'(rdy[0]));
      chk("ready1", 64'(r1), 64'(rdy[1]));
      chk("ready2", 64'(r2), 64'(rdy[2]));
      chk("busA0", a0, expRd(0, RA));
      chk("busB0", b0, expRd(0, RB));
      chk("busA1", a1, expRd(1, RA));
      chk("busB1", b1, expRd(1, RB));
      chk("busA2", {32'b0, a2}, expRd(2, RA));
      chk("busB2", {32'b0, b2}, expRd(2, RB));
   end

   task automatic drive(input logic we, input logic [4:0] w, input logic [63:0] d, input logic [4:0] ra,
                        input logic [4:0] rb);
      @(negedge clk);
      RegWr = we; RW = w; BusW = d; RA = ra; RB = rb;
      #1;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      chk("rstReady", 64'(r0), 64'd0);
      chk("rstBusA", a0, 64'd0);
      chk("rstBusB", b0, 64'd0);
      Reset = 1'b0; RegWr = 1'b1; RW = 5'd5; BusW = 64'hDEAD;
      for (int i = 1; i <= 32; i++) begin
         @(negedge clk);
         if (i == 32) RegWr = 1'b0;
         #1;
         chk("clearReady", 64'(r0), 64'(i == 32));
         chk("clearReadySmall", 64'(r2), 64'(i >= 8));
      end
      for (int i = 0; i < 32; i++) begin
         drive(1'b0, 5'd0, 64'd0, 5'(i), 5'(31 - i));
         chk("clearedA", a0, 64'd0);
         chk("clearedB", b0, 64'd0);
      end
      drive(1'b1, 5'd3, 64'h0123456789ABCDEF, 5'd0, 5'd0);
      drive(1'b0, 5'd0, 64'd0, 5'd3, 5'd3);
      chk("basicA", a0, 64'h0123456789ABCDEF);
      chk("basicB", b0, 64'h0123456789ABCDEF);
      drive(1'b1, 5'd31, '1, 5'd0, 5'd0);
      drive(1'b0, 5'd0, 64'd0, 5'd31, 5'd0);
      chk("zeroReg31", a0, 64'd0);
      chk("zeroReg0Holds31", a1, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("zeroReg0", b1, 64'd0);
      drive(1'b1, 5'd7, 64'h55, 5'd0, 5'd0);
      drive(1'b1, 5'd7, 64'hAA, 5'd7, 5'd0);
      chk("bypassBefore", a0, BYP ? 64'hAA : 64'h55);
      drive(1'b0, 5'd0, 64'd0, 5'd7, 5'd0);
      chk("bypassAfter", a0, 64'hAA);
      drive(1'b1, 5'd6, 64'hCAFEBABE, 5'd0, 5'd0);
      drive(1'b0, 5'd0, 64'd0, 5'd0, 5'd6);
      chk("smallRead", {32'b0, b2}, 64'hCAFEBABE);
      drive(1'b1, 5'd4, 64'h77, 5'd0, 5'd0);
      drive(1'b0, 5'd0, 64'd0, 5'd4, 5'd0);
      chk("preReset", a0, 64'h77);
      @(negedge clk) Reset = 1'b1;
      @(negedge clk) Reset = 1'b0;
      repeat (10) @(negedge clk);
      Reset = 1'b1;
      @(negedge clk) Reset = 1'b0;
      for (int i = 1; i <= 32; i++) begin
         @(negedge clk);
         #1;
         chk("restartReady", 64'(r0), 64'(i == 32));
      end
      drive(1'b0, 5'd0, 64'd0, 5'd4, 5'd4);
      chk("postResetMem4", a0, 64'd0);
      repeat (600) begin
         @(negedge clk);
         Reset = ($urandom % 100) == 0;
         RegWr = 1'($urandom);
         RW = 5'($urandom);
         RA = ($urandom % 4 == 0) ? RW : 5'($urandom);
         RB = ($urandom % 4 == 0) ? RW : 5'($urandom);
         BusW = {$urandom, $urandom};
      end
      @(negedge clk);
      #3;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
